probki_linia_opozniajaca: RTL and testbench
===========================================

# probki_linia_opozniajaca

- Sample delay line for the FIR core; sits directly upstream of `multiplier`.
- Accepts new 16-bit Q1.15 input samples through a valid/ready handshake and holds each one in a one-entry staging register.
- Commits the staged sample into an N-tap circular buffer on the FSM's `FSM_nowa_shift` command.
- Returns tap x[n-k] as `shift_out` for the address `adres` supplied by `licznik_petli`.

## Interface
Parameters:
- `N_TAPS`, 32: number of stored samples (taps); 2..32.
- `DATA_W`, 16: sample width, Q1.15 two's complement.
- `ADR_W`, 5: width of `adres`; must satisfy 2^ADR_W >= N_TAPS.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `probka_wej` in DATA_W: incoming sample.
- `probka_valid` in 1: `probka_wej` valid.
- `probka_ready` out 1: staging register empty, so a sample can be accepted.
- `probka_dostepna` out 1: staged sample waiting for commit (to `fsm`).
- `FSM_nowa_shift` in 1: commit staged sample into the buffer.
- `FSM_reset_shift` in 1: clear buffer contents, pointer and count.
- `adres` in ADR_W: tap index k, 0 = newest sample.
- `shift_out` out DATA_W: registered tap value x[n-k] (to `multiplier`).
- `liczba_probek` out ADR_W+1: committed samples, saturating at N_TAPS.
- `pelny` out 1: `liczba_probek == N_TAPS`.
- `blad_shift` out 1: sticky commit-without-sample error (see Configuration).

## Operation
- **Staging**
  - `probka_ready = !probka_dostepna`.
  - On `probka_valid && probka_ready`, `probka_wej` is captured and `probka_dostepna` is set.
  - Samples are never overwritten while staged.
- **Commit**
  - On `FSM_nowa_shift && probka_dostepna`:
    - the staged sample is written to `buf[wr_ptr]`;
    - `wr_ptr` advances modulo N_TAPS (N_TAPS-1 wraps to 0);
    - `liczba_probek` increments, saturating at N_TAPS;
    - `probka_dostepna` clears.
- **Commit with no sample:** `FSM_nowa_shift` without `probka_dostepna` leaves the buffer, pointer and count unchanged.
- **Read**
  - newest index = (wr_ptr - 1) mod N_TAPS.
  - Next `shift_out` = `buf[(newest - adres) mod N_TAPS]`.
  - `shift_out` is 0 when `adres >= N_TAPS` or `adres >= liczba_probek`. Unfilled taps read zero, which gives zero initial conditions.
- **FSM_reset_shift**
  - Zeroes all entries, `wr_ptr`, `liczba_probek` and `shift_out`.
  - The staging register and `probka_dostepna` are kept, so a pending sample is not lost.
- **rst:** clears everything, including staging.
- **Simultaneous events**
  - `FSM_reset_shift` together with `FSM_nowa_shift`: reset wins, the staged sample stays staged.
  - `FSM_reset_shift` together with a handshake: the capture still happens.
  - Commit and read in the same cycle: the read uses the pre-commit buffer and pointer.
- **Arithmetic:** no arithmetic on the data; samples pass bit-exact.

## Timing
- Reset values:
  - `probka_ready`=1
  - `probka_dostepna`=0
  - `shift_out`=0
  - `liczba_probek`=0
  - `pelny`=0
  - `blad_shift`=0
- Handshake: a capture edge makes `probka_ready` fall and `probka_dostepna` rise in the next cycle. The next sample can be accepted one cycle after the commit edge.
- Read latency is 1 cycle: `adres` presented in cycle t gives `shift_out` valid in cycle t+1. `licznik_petli` address is aligned with `FSM_Acc_en` delayed by one.
- Commit is visible to reads one cycle after the commit edge.
- `pelny` and `liczba_probek` update on the commit edge.
- No combinational path from any input to any output.

## Configuration
- Macro: `PROBKI_BLAD_SHIFT_EN`.
- With the macro defined:
  - `blad_shift` sets on `FSM_nowa_shift && !probka_dostepna`;
  - it stays set until `FSM_reset_shift` or `rst`;
  - if the set and clear conditions occur in the same cycle, clear wins.
- Without the macro: `blad_shift` is tied to 0 and no flag register is synthesized.

## Test plan
- **Reset:** assert `rst` for 2 cycles, then read any adres → `shift_out`=0, `probka_ready`=1, `liczba_probek`=0, `pelny`=0.
- **Handshake and commit:**
  - Push 0x4000 (valid=1) → `probka_ready`=0 and `probka_dostepna`=1 next cycle.
  - Assert `FSM_nowa_shift` → `liczba_probek`=1.
  - Set adres=0 → `shift_out`=0x4000 one cycle later; adres=1 → 0x0000.
- **Ordering:**
  - Commit 0xC000, then 0x4000, then 0x2000.
  - adres 0,1,2 → 0x2000, 0x4000, 0xC000, each 1 cycle after its address.
- **Wrap-around and full (N_TAPS=4):**
  - Commit 1..6 → `pelny`=1 and `liczba_probek`=4.
  - adres 0..3 → 6,5,4,3; adres 4 → 0.
- **Reset-shift with a pending sample:**
  - Stage 0x1234 and assert `FSM_reset_shift` together with `FSM_nowa_shift`.
  - Buffer clears, `probka_dostepna` stays 1.
  - Next commit → adres 0 reads 0x1234, `liczba_probek`=1.
- **Error flag:** `FSM_nowa_shift` with nothing staged → `blad_shift`=1 (macro defined) or 0 (undefined), with buffer and count unchanged; `FSM_reset_shift` → `blad_shift`=0.

Source files
------------

// File: rtl/probki_linia_opozniajaca.sv
// Sample delay line for the FIR core: one-entry staging register feeding an
// N-tap circular buffer with a registered tap read. Optional macro: PROBKI_BLAD_SHIFT_EN.
module probki_linia_opozniajaca #(
  parameter int N_TAPS = 32,
  parameter int DATA_W = 16,
  parameter int ADR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] probka_wej,
  input  logic              probka_valid,
  output logic              probka_ready,
  output logic              probka_dostepna,
  input  logic              FSM_nowa_shift,
  input  logic              FSM_reset_shift,
  input  logic [ADR_W-1:0]  adres,
  output logic [DATA_W-1:0] shift_out,
  output logic [ADR_W:0]    liczba_probek,
  output logic              pelny,
  output logic              blad_shift
);

  localparam int CW = ADR_W + 1;

  logic [DATA_W-1:0] mem_reg [N_TAPS];
  logic [DATA_W-1:0] staged_reg;
  logic              dostepna_reg;
  logic [ADR_W-1:0]  wr_ptr_reg;
  logic [ADR_W-1:0]  wr_ptr_next;
  logic [CW-1:0]     count_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;

  logic          capture;
  logic          commit;
  logic [CW-1:0] idx_wide;
  logic [ADR_W-1:0] rd_idx;
  logic          in_range;

  assign capture = probka_valid && !dostepna_reg;
  // A buffer clear overrides a commit; the staged sample is then kept.
  assign commit  = FSM_nowa_shift && dostepna_reg && !FSM_reset_shift;

  // Staging register: rst clears it, FSM_reset_shift does not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      staged_reg   <= '0;
      dostepna_reg <= 1'b0;
    end else if (capture) begin
      staged_reg   <= probka_wej;
      dostepna_reg <= 1'b1;
    end else if (commit) begin
      dostepna_reg <= 1'b0;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg + 1'b1;
    if (wr_ptr_reg == ADR_W'(N_TAPS - 1)) begin
      wr_ptr_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || FSM_reset_shift) begin
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (commit) begin
      wr_ptr_reg <= wr_ptr_next;
      if (count_reg != CW'(N_TAPS)) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || FSM_reset_shift) begin
      for (int i = 0; i < N_TAPS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (commit) begin
      mem_reg[wr_ptr_reg] <= staged_reg;
    end
  end

  // Tap k lives at (wr_ptr - 1 - k) mod N; N-1 is added first so the sum never underflows.
  always_comb begin
    in_range = ({1'b0, adres} < CW'(N_TAPS)) && ({1'b0, adres} < count_reg);
    idx_wide = {1'b0, wr_ptr_reg} + CW'(N_TAPS - 1) - {1'b0, adres};
    if (idx_wide >= CW'(N_TAPS)) begin
      idx_wide = idx_wide - CW'(N_TAPS);
    end
    rd_idx     = in_range ? idx_wide[ADR_W-1:0] : '0;
    shift_next = in_range ? mem_reg[rd_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || FSM_reset_shift) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= shift_next;
    end
  end

`ifdef PROBKI_BLAD_SHIFT_EN
  logic blad_reg;

  always_ff @(posedge clk) begin
    if (rst || FSM_reset_shift) begin
      blad_reg <= 1'b0;
    end else if (FSM_nowa_shift && !dostepna_reg) begin
      blad_reg <= 1'b1;
    end
  end

  assign blad_shift = blad_reg;
`else
  assign blad_shift = 1'b0;
`endif

  assign probka_ready    = !dostepna_reg;
  assign probka_dostepna = dostepna_reg;
  assign shift_out       = shift_reg;
  assign liczba_probek   = count_reg;
  assign pelny           = (count_reg == CW'(N_TAPS));

endmodule

// File: tb/tb_probki_linia_opozniajaca.sv
// Directed bench for probki_linia_opozniajaca built with N_TAPS=4, ADR_W=3
// so wrap-around, saturation and out-of-range addresses are reachable.
module tb_probki_linia_opozniajaca;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] probka_wej;
  logic          probka_valid;
  logic          probka_ready;
  logic          probka_dostepna;
  logic          FSM_nowa_shift;
  logic          FSM_reset_shift;
  logic [AW-1:0] adres;
  logic [DW-1:0] shift_out;
  logic [AW:0]   liczba_probek;
  logic          pelny;
  logic          blad_shift;

  int vec_count = 0;
  int miscompares = 0;

  probki_linia_opozniajaca #(.N_TAPS(N), .DATA_W(DW), .ADR_W(AW)) dut (
    .clk(clk), .rst(rst), .probka_wej(probka_wej), .probka_valid(probka_valid),
    .probka_ready(probka_ready), .probka_dostepna(probka_dostepna),
    .FSM_nowa_shift(FSM_nowa_shift), .FSM_reset_shift(FSM_reset_shift),
    .adres(adres), .shift_out(shift_out), .liczba_probek(liczba_probek),
    .pelny(pelny), .blad_shift(blad_shift)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          n;
    logic          r;
    logic [AW-1:0] a;
    logic          e_ready;
    logic          e_dost;
    logic [AW:0]   e_cnt;
    logic [DW-1:0] e_shift;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic n,
                       input logic r, input logic [AW-1:0] a);
    probka_valid = v; probka_wej = d; FSM_nowa_shift = n;
    FSM_reset_shift = r; adres = a;
  endtask

  // One edge with the given inputs; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    drive(1'b1, d, 1'b0, 1'b0, '0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0); tick();
  endtask

  task automatic read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    drive(1'b0, '0, 1'b0, 1'b0, a); tick();
    check(name, 32'(shift_out), 32'(exp));
    $display("read adres=%0d shift_out=0x%04h", a, shift_out);
  endtask

  logic exp_blad;

  initial begin
`ifdef PROBKI_BLAD_SHIFT_EN
    exp_blad = 1'b1;
`else
    exp_blad = 1'b0;
`endif
    //          v  d        n  r  a   rdy dst cnt shift
    vecs[0]  = '{1, 16'h4000, 0, 0, 0, 0, 1, 0, 16'h0000};
    vecs[1]  = '{0, 16'h0000, 1, 0, 0, 1, 0, 1, 16'h0000};
    vecs[2]  = '{0, 16'h0000, 0, 0, 0, 1, 0, 1, 16'h4000};
    vecs[3]  = '{0, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h0000};
    vecs[4]  = '{0, 16'h0000, 0, 1, 0, 1, 0, 0, 16'h0000};
    vecs[5]  = '{1, 16'hC000, 0, 0, 0, 0, 1, 0, 16'h0000};
    vecs[6]  = '{0, 16'h0000, 1, 0, 0, 1, 0, 1, 16'h0000};
    vecs[7]  = '{1, 16'h4000, 0, 0, 0, 0, 1, 1, 16'hC000};
    vecs[8]  = '{0, 16'h0000, 1, 0, 0, 1, 0, 2, 16'hC000};
    vecs[9]  = '{1, 16'h2000, 0, 0, 0, 0, 1, 2, 16'h4000};
    vecs[10] = '{0, 16'h0000, 1, 0, 0, 1, 0, 3, 16'h4000};
    vecs[11] = '{0, 16'h0000, 0, 0, 0, 1, 0, 3, 16'h2000};
    vecs[12] = '{0, 16'h0000, 0, 0, 1, 1, 0, 3, 16'h4000};
    vecs[13] = '{0, 16'h0000, 0, 0, 2, 1, 0, 3, 16'hC000};
    vecs[14] = '{0, 16'h0000, 0, 0, 3, 1, 0, 3, 16'h0000};

    // Reset
    drive(1'b0, '0, 1'b0, 1'b0, 3'd2);
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    check("reset_shift_out", 32'(shift_out), 32'h0);
    check("reset_ready", 32'(probka_ready), 32'd1);
    check("reset_dostepna", 32'(probka_dostepna), 32'd0);
    check("reset_count", 32'(liczba_probek), 32'd0);
    check("reset_pelny", 32'(pelny), 32'd0);
    check("reset_blad", 32'(blad_shift), 32'd0);

    // Handshake, commit and ordering table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].n, vecs[i].r, vecs[i].a);
      tick();
      $display("vec %0d: ready=%0b dost=%0b cnt=%0d shift=0x%04h", i,
               probka_ready, probka_dostepna, liczba_probek, shift_out);
      check($sformatf("vec%0d_ready", i), 32'(probka_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_dost", i), 32'(probka_dostepna), 32'(vecs[i].e_dost));
      check($sformatf("vec%0d_cnt", i), 32'(liczba_probek), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_shift", i), 32'(shift_out), 32'(vecs[i].e_shift));
    end

    // Wrap-around and saturation
    drive(1'b0, '0, 1'b0, 1'b1, '0); tick();
    for (int s = 1; s <= 6; s++) begin
      push(16'(s));
    end
    check("wrap_pelny", 32'(pelny), 32'd1);
    check("wrap_count", 32'(liczba_probek), 32'd4);
    read(3'd0, 16'd6, "wrap_a0");
    read(3'd1, 16'd5, "wrap_a1");
    read(3'd2, 16'd4, "wrap_a2");
    read(3'd3, 16'd3, "wrap_a3");
    read(3'd4, 16'd0, "wrap_a4");

    // Reset-shift together with a commit while a sample is pending
    drive(1'b1, 16'h1234, 1'b0, 1'b0, '0); tick();
    drive(1'b0, '0, 1'b1, 1'b1, '0); tick();
    check("rs_dostepna", 32'(probka_dostepna), 32'd1);
    check("rs_count", 32'(liczba_probek), 32'd0);
    check("rs_pelny", 32'(pelny), 32'd0);
    read(3'd1, 16'd0, "rs_cleared");
    drive(1'b0, '0, 1'b1, 1'b0, '0); tick();
    check("rs_commit_count", 32'(liczba_probek), 32'd1);
    read(3'd0, 16'h1234, "rs_a0");

    // Commit with nothing staged
    drive(1'b0, '0, 1'b1, 1'b0, '0); tick();
    check("err_blad", 32'(blad_shift), 32'(exp_blad));
    check("err_count", 32'(liczba_probek), 32'd1);
    read(3'd0, 16'h1234, "err_a0");
    check("err_blad_sticky", 32'(blad_shift), 32'(exp_blad));
    drive(1'b0, '0, 1'b0, 1'b1, '0); tick();
    check("err_cleared", 32'(blad_shift), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
